// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 core: opcodes, FSM states and the CC helper.
package lc3_pkg;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_MEM_RD     = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_MEM_WR     = 3'd6
  } state_e;

  // NZP condition code of a result, one-hot
  function automatic logic [2:0] cc_of(input logic [15:0] v);
    logic [2:0] cc;
    if (v[15]) begin
      cc = 3'b100;
    end else if (v == 16'h0000) begin
      cc = 3'b010;
    end else begin
      cc = 3'b001;
    end
    return cc;
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// 8x16 register file: two asynchronous read ports, one synchronous write port.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  ra_a_i,
  input  logic [2:0]  ra_b_i,
  output logic [15:0] rd_a_o,
  output logic [15:0] rd_b_o,
  input  logic        we_i,
  input  logic [2:0]  wa_i,
  input  logic [15:0] wd_i
);

  logic [15:0] regs_q [8];

  // Register storage with synchronous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= 16'h0000;
      end
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = regs_q[ra_a_i];
  assign rd_b_o = regs_q[ra_b_i];

endmodule

// File: rtl/lc3.sv
// Multicycle LC-3 core with separate instruction and data ports.
module lc3
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  output logic [15:0] pc,
  output logic        instrmem_rd,
  input  logic [15:0] Instr_dout,
  output logic [15:0] Data_addr,
  output logic [15:0] Data_din,
  input  logic [15:0] Data_dout,
  output logic        Data_rd,
  output logic        D_macc,
  output logic        I_macc
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, ea_q, ea_d;
  logic [2:0]  cc_q, cc_d;
  logic        ind_q, ind_d;
  logic        imacc_q, dmacc_q, data_rd_q;
  logic [15:0] data_addr_q, data_addr_d, data_din_q, data_din_d;

  logic [3:0]  opcode;
  logic [15:0] sext5, sext6, sext9, sext11, src_a, src_b, operand, alu;
  logic [2:0]  ra_b;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;

  assign opcode = ir_q[15:12];
  assign sext5  = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sext6  = {{10{ir_q[5]}}, ir_q[5:0]};
  assign sext9  = {{7{ir_q[8]}}, ir_q[8:0]};
  assign sext11 = {{5{ir_q[10]}}, ir_q[10:0]};
  // Stores read their source from the DR field rather than SR2
  assign ra_b   = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) ? ir_q[11:9] : ir_q[2:0];

  lc3_regfile u_rf (
    .clk_i  (clock),
    .rst_i  (reset),
    .ra_a_i (ir_q[8:6]),
    .ra_b_i (ra_b),
    .rd_a_o (src_a),
    .rd_b_o (src_b),
    .we_i   (rf_we),
    .wa_i   (rf_wa),
    .wd_i   (rf_wd)
  );

  // Operate-instruction datapath
  always_comb begin
    operand = ir_q[5] ? sext5 : src_b;
    case (opcode)
      OP_ADD:  alu = src_a + operand;
      OP_AND:  alu = src_a & operand;
      OP_NOT:  alu = ~src_a;
      default: alu = ea_q;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cc_d    = cc_q;
    ea_d    = ea_q;
    ind_d   = ind_q;
    rf_we   = 1'b0;
    rf_wa   = ir_q[11:9];
    rf_wd   = alu;
    case (state_q)
      S_FETCH: state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (complete_instr) begin
          ir_d    = Instr_dout;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH_WAIT;
        end
      end
      S_DECODE: begin
        ind_d   = 1'b0;
        state_d = S_EXEC;
        case (opcode)
          OP_LDR, OP_STR: ea_d = src_a + sext6;
          OP_JSR:         ea_d = ir_q[11] ? pc_q + sext11 : src_a;
          default:        ea_d = pc_q + sext9;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
            rf_we = 1'b1;
            cc_d  = cc_of(alu);
          end
          OP_BR: begin
            if ((ir_q[11:9] & cc_q) != 3'b000) begin
              pc_d = ea_q;
            end else begin
              pc_d = pc_q;
            end
          end
          OP_JMP: pc_d = src_a;
          OP_JSR: begin
            rf_we = 1'b1;
            rf_wa = 3'd7;
            rf_wd = pc_q;
            pc_d  = ea_q;
          end
          OP_LD, OP_LDR, OP_LDI, OP_STI: state_d = S_MEM_RD;
          OP_ST, OP_STR:                 state_d = S_MEM_WR;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_MEM_RD: state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (!complete_data) begin
          state_d = S_MEM_WAIT;
        end else if ((opcode == OP_LDI || opcode == OP_STI) && !ind_q) begin
          ea_d    = Data_dout;
          ind_d   = 1'b1;
          state_d = (opcode == OP_LDI) ? S_MEM_RD : S_MEM_WR;
        end else begin
          rf_we   = 1'b1;
          rf_wd   = Data_dout;
          cc_d    = cc_of(Data_dout);
          state_d = S_FETCH;
        end
      end
      S_MEM_WR: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Bus outputs are registered from the upcoming state
  always_comb begin
    data_addr_d = (state_d == S_MEM_RD || state_d == S_MEM_WR) ? ea_d : data_addr_q;
    data_din_d  = (state_d == S_MEM_WR) ? src_b : data_din_q;
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      cc_q        <= 3'b010;
      ea_q        <= 16'h0000;
      ind_q       <= 1'b0;
      imacc_q     <= 1'b0;
      dmacc_q     <= 1'b0;
      data_rd_q   <= 1'b1;
      data_addr_q <= 16'h0000;
      data_din_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cc_q        <= cc_d;
      ea_q        <= ea_d;
      ind_q       <= ind_d;
      imacc_q     <= (state_d == S_FETCH) || (state_d == S_FETCH_WAIT);
      dmacc_q     <= (state_d == S_MEM_RD) || (state_d == S_MEM_WAIT) || (state_d == S_MEM_WR);
      data_rd_q   <= (state_d != S_MEM_WR);
      data_addr_q <= data_addr_d;
      data_din_q  <= data_din_d;
    end
  end

  assign pc          = pc_q;
  assign instrmem_rd = imacc_q;
  assign I_macc      = imacc_q;
  assign D_macc      = dmacc_q;
  assign Data_addr   = data_addr_q;
  assign Data_din    = data_din_q;
  // A reset landing on a store cycle must suppress the write immediately
  assign Data_rd     = data_rd_q | reset;

endmodule

// File: tb/tb_lc3.sv
// Directed program test for the lc3 core with behavioural instruction/data memories.
module tb_lc3;

  logic        clock = 1'b0;
  logic        reset, complete_instr, complete_data;
  logic [15:0] pc, Instr_dout, Data_addr, Data_din, Data_dout;
  logic        instrmem_rd, Data_rd, D_macc, I_macc;

  logic [15:0] imem [0:65535];
  logic [15:0] dmem [0:65535];

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt;
  logic [15:0] wr_addr, wr_din;
  logic [15:0] alog [$];

  always #5 clock = ~clock;

  lc3 #(.RESET_PC(16'h3000)) dut (
    .clock          (clock),
    .reset          (reset),
    .complete_instr (complete_instr),
    .complete_data  (complete_data),
    .pc             (pc),
    .instrmem_rd    (instrmem_rd),
    .Instr_dout     (Instr_dout),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout),
    .Data_rd        (Data_rd),
    .D_macc         (D_macc),
    .I_macc         (I_macc)
  );

  always @(posedge clock) begin
    Instr_dout <= imem[pc];
    if (!Data_rd) dmem[Data_addr] <= Data_din;
    else          Data_dout <= dmem[Data_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Run from a FETCH sample to the next FETCH, logging bus activity
  task automatic exec_one(input string tag, input int exp_cyc);
    int   n;
    logic prev, done;
    n = 0; done = 1'b0; prev = I_macc; wr_cnt = 0;
    alog.delete();
    while (!done && n < 40) begin
      step();
      n++;
      if (!Data_rd) begin
        wr_cnt++;
        wr_addr = Data_addr;
        wr_din  = Data_din;
      end
      if (D_macc && (alog.size() == 0 || alog[$] !== Data_addr)) alog.push_back(Data_addr);
      if (!prev && I_macc) done = 1'b1;
      prev = I_macc;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    if (exp_cyc > 0) chk({tag, "_cycles"}, n, exp_cyc);
  endtask

  initial begin
    logic [15:0] prog [25];
    prog = '{16'h5260, 16'h1261, 16'h127E, 16'h5260, 16'h1261, 16'hE404, 16'h5920, 16'h1925,
             16'h1241, 16'h7280, 16'h14A1, 16'h193F, 16'h03FB,
             16'hA642, 16'h2A41, 16'h6D40, 16'h1021, 16'h0403, 16'h4805, 16'hB03C,
             16'h5B60, 16'h1B7F, 16'hC140, 16'h0000, 16'hC1C0};
    for (int a = 0; a < 65536; a++) begin
      imem[a] = 16'h0000;
      dmem[a] = 16'h0000;
    end
    for (int k = 0; k < 25; k++) imem[16'h3000 + k] = prog[k];
    imem[16'h0000] = 16'h0FFF;
    dmem[16'h0000] = 16'hBEEF;
    dmem[16'h3050] = 16'h3060;
    dmem[16'h3060] = 16'h8001;

    reset = 1'b1; complete_instr = 1'b1; complete_data = 1'b1;
    step(); step();
    chk("rst_pc", pc, 16'h3000);
    chk("rst_imrd", instrmem_rd, 1'b0);
    chk("rst_drd", Data_rd, 1'b1);
    chk("rst_imacc", I_macc, 1'b0);
    chk("rst_dmacc", D_macc, 1'b0);

    complete_instr = 1'b0; reset = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("stall_pc", pc, 16'h3000);
    chk("stall_r1", dut.u_rf.regs_q[1], 16'h0000);
    chk("stall_imrd", instrmem_rd, 1'b1);
    complete_instr = 1'b1;
    step();
    chk("fetch_ir", dut.ir_q, 16'h5260);
    chk("fetch_pc", pc, 16'h3001);
    step(); step();
    chk("and_r1", dut.u_rf.regs_q[1], 16'h0000);
    chk("and_cc", dut.cc_q, 3'b010);

    exec_one("add1", 4);
    chk("add1_r1", dut.u_rf.regs_q[1], 16'h0001);
    chk("add1_cc", dut.cc_q, 3'b001);
    exec_one("addm2", 4);
    chk("addm2_r1", dut.u_rf.regs_q[1], 16'hFFFF);
    chk("addm2_cc", dut.cc_q, 3'b100);

    for (int k = 0; k < 5; k++) exec_one("setup", 4);
    chk("lea_r2", dut.u_rf.regs_q[2], 16'h300A);

    for (int i = 0; i < 5; i++) begin
      exec_one("dbl", 4);
      exec_one("str", 0);
      chk("str_wrcnt", wr_cnt, 1);
      chk("str_addr", wr_addr, 16'h300A + i[15:0]);
      chk("str_din", wr_din, 16'd2 << i);
      exec_one("inc", 4);
      exec_one("dec", 4);
      exec_one("brp", 4);
    end
    for (int i = 0; i < 5; i++) chk("ram", dmem[16'h300A + i], 16'd2 << i);
    chk("loop_exit_pc", pc, 16'h300D);

    exec_one("ldi", 8);
    chk("ldi_naddr", alog.size(), 2);
    chk("ldi_addr0", alog[0], 16'h3050);
    chk("ldi_addr1", alog[1], 16'h3060);
    chk("ldi_r3", dut.u_rf.regs_q[3], 16'h8001);
    chk("ldi_cc", dut.cc_q, 3'b100);
    exec_one("ld", 6);
    chk("ld_r5", dut.u_rf.regs_q[5], 16'h3060);
    chk("ld_cc", dut.cc_q, 3'b001);
    exec_one("ldr", 6);
    chk("ldr_r6", dut.u_rf.regs_q[6], 16'h8001);

    exec_one("add_r0", 4);
    exec_one("brz", 4);
    chk("brz_pc", pc, 16'h3012);
    exec_one("jsr", 4);
    chk("jsr_pc", pc, 16'h3018);
    chk("jsr_r7", dut.u_rf.regs_q[7], 16'h3013);
    exec_one("jmp", 4);
    chk("jmp_pc", pc, 16'h3013);

    exec_one("sti", 0);
    chk("sti_wrcnt", wr_cnt, 1);
    chk("sti_addr", wr_addr, 16'h3060);
    chk("sti_din", wr_din, 16'h0001);
    chk("sti_cc", dut.cc_q, 3'b001);

    exec_one("and_r5", 4);
    exec_one("add_r5", 4);
    exec_one("jmp_r5", 4);
    chk("jmp_r5_pc", pc, 16'hFFFF);
    exec_one("nop_wrap", 4);
    chk("wrap_pc", pc, 16'h0000);

    imem[16'h3000] = 16'h7280;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 20 && Data_rd; k++) step();
    chk("abort_store_seen", Data_rd, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_drd", Data_rd, 1'b1);
    step(); step();
    reset = 1'b0;
    chk("abort_ram", dmem[16'h0000], 16'hBEEF);
    chk("abort_pc", pc, 16'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
